// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding and default sizing for the burst RAM controller.
package ram_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int LEN_WIDTH_DEF = 8;
  localparam int SKID_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 2-entry FIFO that absorbs registered RAM read data under downstream backpressure.
module ram_rd_skid
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = push_data;
    wptr_d = push ? ~wptr_q : wptr_q;
    rptr_d = pop ? ~rptr_q : rptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[rptr_q];
  assign count = count_q;
  assign empty = count_q == '0;
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: one-command-at-a-time burst read/write controller in front of a
// single-port synchronous RAM with 1-cycle read latency.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d, issue_rem_q, issue_rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            skid_count;
  logic                  skid_empty, wr_beat, rd_pop, rd_issue;
  logic [2:0]            occ;
  ram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_q),
    .pop       (rd_pop),
    .head      (rd_data),
    .count     (skid_count),
    .empty     (skid_empty)
  );
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wr_ready = state_q == WRITE;
  assign rd_valid = state_q == READ && !skid_empty;
  assign wr_beat = wr_ready && wr_valid;
  assign rd_pop = rd_valid && rd_ready;
  // Occupancy after this cycle's pop lets a read issue in the same cycle a word leaves,
  // keeping 1 word/cycle while never exceeding the two buffer slots.
  assign occ = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, rd_pop};
  assign rd_issue = state_q == READ && issue_rem_q != '0 && occ < 3'(SKID_DEPTH);
  assign ram_we = wr_beat;
  assign ram_addr = cur_addr_q;
  assign ram_d = wr_beat ? wr_data : '0;
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    rem_d = rem_q;
    issue_rem_d = issue_rem_q;
    inflight_d = rd_issue;
    case (state_q)
      IDLE: if (cmd_valid) begin
        cur_addr_d = cmd_addr;
        rem_d = cmd_len;
        issue_rem_d = cmd_len;
        state_d = cmd_len == '0 ? DONE : (cmd_write ? WRITE : READ);
      end
      WRITE: if (wr_beat) begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
        rem_d = rem_q - LEN_WIDTH'(1);
        state_d = rem_q == LEN_WIDTH'(1) ? DONE : WRITE;
      end
      READ: begin
        cur_addr_d = rd_issue ? cur_addr_q + ADDR_WIDTH'(1) : cur_addr_q;
        issue_rem_d = rd_issue ? issue_rem_q - LEN_WIDTH'(1) : issue_rem_q;
        rem_d = rd_pop ? rem_q - LEN_WIDTH'(1) : rem_q;
        state_d = rd_pop && rem_q == LEN_WIDTH'(1) ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      rem_q <= '0;
      issue_rem_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q <= rem_d;
      issue_rem_q <= issue_rem_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: scoreboard bench with a behavioural 128x32 sync RAM behind the controller.
module tb_ram_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        busy, done, ram_we;
  logic [6:0]  ram_addr;
  logic [31:0] ram_d, ram_q;
  logic [31:0] mem [128];
  logic [31:0] shadow [128];
  logic [31:0] rd_exp [$];
  logic [38:0] wr_exp [$];
  int checks = 0, failures = 0;
  int cyc = 0, hs_cyc = 0, we_cnt = 0, done_cnt = 0, pop_cnt = 0;
  int rv_rise_cyc = 0, last_pop_cyc = 0;
  logic rv_prev = 1'b0;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected writes/reads whenever the DUT presents one.
  always @(negedge clk) if (rst_n) begin
    if (ram_we) begin
      we_cnt++;
      if (wr_exp.size() == 0) chk("unexpected_ram_we", {25'd0, ram_addr, ram_d}, 64'd0);
      else chk("ram_write", {25'd0, ram_addr, ram_d}, {25'd0, wr_exp.pop_front()});
    end
    if (done) done_cnt++;
    if (rd_valid && !rv_prev) rv_rise_cyc = cyc;
    rv_prev = rd_valid;
    if (rd_valid && rd_ready) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      if (rd_exp.size() == 0) chk("unexpected_rd_beat", {32'd0, rd_data}, 64'd0);
      else chk("rd_data", {32'd0, rd_data}, {32'd0, rd_exp.pop_front()});
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_flags"}, {58'd0, cmd_ready, wr_ready, rd_valid, busy, done, ram_we}, 64'b100000);
    chk({nm, "_ram_addr"}, {57'd0, ram_addr}, 64'd0);
    chk({nm, "_rd_data"}, {32'd0, rd_data}, 64'd0);
    chk({nm, "_ram_d"}, {32'd0, ram_d}, 64'd0);
  endtask

  task automatic send_cmd(input logic w, input logic [6:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  task automatic wr_burst(input logic [6:0] a, input int l, input logic [31:0] base, input bit gap);
    int d0 = done_cnt;
    int w0 = we_cnt;
    send_cmd(1'b1, a, 8'(l));
    for (int i = 0; i < l; i++) begin
      logic [6:0] ad = a + 7'(i);
      wr_valid = 1'b1;
      wr_data = base + 32'(i);
      shadow[ad] = wr_data;
      wr_exp.push_back({ad, wr_data});
      @(posedge clk); #1;
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
    end
    wr_valid = 1'b0;
    wait_idle();
    chk("wr_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("wr_we_cycles", 64'(we_cnt - w0), 64'(l));
    chk("wr_queue_drained", 64'(wr_exp.size()), 64'd0);
  endtask

  task automatic push_rd(input logic [6:0] a, input int l);
    for (int i = 0; i < l; i++) rd_exp.push_back(shadow[a + 7'(i)]);
  endtask

  initial begin
    int d0, p0, w0, n;
    #2 rst_n = 1'b0;
    wr_data = 32'h1234_5678;
    #1 chk_reset_outputs("t1_reset");
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // T2: write burst wrapping past the top of the address space, with an idle gap
    wr_burst(7'h7E, 4, 32'h0000_00A0, 1'b1);
    chk("t2_mem7e", {32'd0, mem[7'h7E]}, 64'hA0);
    chk("t2_mem7f", {32'd0, mem[7'h7F]}, 64'hA1);
    chk("t2_mem00", {32'd0, mem[7'h00]}, 64'hA2);
    chk("t2_mem01", {32'd0, mem[7'h01]}, 64'hA3);
    // T3: streaming read, rd_ready held high
    rd_ready = 1'b1;
    d0 = done_cnt; p0 = pop_cnt; w0 = we_cnt;
    push_rd(7'h7E, 4);
    send_cmd(1'b0, 7'h7E, 8'd4);
    wait_idle();
    chk("t3_first_rv_latency", 64'(rv_rise_cyc - hs_cyc), 64'd2);
    chk("t3_consecutive", 64'(last_pop_cyc - rv_rise_cyc), 64'd3);
    chk("t3_beats", 64'(pop_cnt - p0), 64'd4);
    chk("t3_done", 64'(done_cnt - d0), 64'd1);
    chk("t3_no_we", 64'(we_cnt - w0), 64'd0);
    // T4: 16-word read with a 5-cycle stall mid-burst
    wr_burst(7'h10, 16, 32'hB000_0000, 1'b0);
    d0 = done_cnt; p0 = pop_cnt;
    push_rd(7'h10, 16);
    send_cmd(1'b0, 7'h10, 8'd16);
    repeat (4) @(posedge clk);
    #1 rd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t4_outstanding", {57'd0, ram_addr}, {57'd0, 7'h10 + 7'(pop_cnt - p0) + 7'd2});
    rd_ready = 1'b1;
    wait_idle();
    chk("t4_beats", 64'(pop_cnt - p0), 64'd16);
    chk("t4_done", 64'(done_cnt - d0), 64'd1);
    chk("t4_queue_drained", 64'(rd_exp.size()), 64'd0);
    // T5: zero-length commands touch nothing and finish immediately
    w0 = we_cnt; p0 = pop_cnt;
    for (int k = 0; k < 2; k++) begin
      send_cmd(k[0], 7'h05, 8'd0);
      chk("t5_done_now", {61'd0, done, busy, cmd_ready}, 64'b110);
      @(posedge clk); #1;
      chk("t5_done_gone", {61'd0, done, busy, cmd_ready}, 64'b001);
    end
    chk("t5_no_access", 64'((we_cnt - w0) + (pop_cnt - p0)), 64'd0);
    // T6: reset after 3 of 8 read beats, then a fresh read
    d0 = done_cnt; p0 = pop_cnt;
    push_rd(7'h10, 8);
    send_cmd(1'b0, 7'h10, 8'd8);
    n = 0;
    while (pop_cnt - p0 < 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_three_beats", 64'(pop_cnt - p0), 64'd3);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_reset");
    rd_exp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt; p0 = pop_cnt;
    push_rd(7'h7E, 2);
    send_cmd(1'b0, 7'h7E, 8'd2);
    wait_idle();
    chk("t6_beats", 64'(pop_cnt - p0), 64'd2);
    chk("t6_done", 64'(done_cnt - d0), 64'd1);
    chk("final_rd_queue", 64'(rd_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
